mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data-memory port between the CPU memory stage and the DMA engine.
- CPU writes are posted into a small write buffer. CPU reads are held as a single-cycle-pulse request and answered with a one-cycle valid.
- DMA uses a level request/done handshake.
- A registered FSM issues one memory transaction at a time, with CPU-biased fair arbitration.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WBUF_DEPTH, 4, CPU posted-write FIFO entries (power of 2, >=2)
CPU_BURST, 2, max consecutive CPU grants while DMA is waiting

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cpu_en  in  1  CPU read request, single-cycle pulse
cpu_wr_en  in  1  CPU write, one entry pushed per cycle high
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_valid  out  1  read data valid, one-cycle pulse
cpu_rdata  out  DATA_W  last CPU read data
cpu_wbuf_full  out  1  write buffer holds WBUF_DEPTH entries
dma_req  in  1  DMA request level; dma_wr/addr/wdata stable until dma_done
dma_wr  in  1  1=write 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_done  out  1  DMA transaction complete, one-cycle pulse
dma_rdata  out  DATA_W  DMA read data, valid with dma_done
mem_req  out  1  memory request, held until mem_ack
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion pulse; mem_rdata valid same cycle
mem_rdata  in  DATA_W  memory read data
arb_idle  out  1  FSM IDLE, buffer empty, no read pending, dma_req low
err_ovf  out  1  sticky: write pushed while full and not popping
err_rd  out  1  sticky: cpu_en while a read already pending

Behaviour:
- Reset (async, any time):
  - FSM goes to IDLE; buffer emptied; rd_pend and streak cleared; sticky errors cleared.
  - All outputs 0 except arb_idle=1; cpu_rdata and dma_rdata are 0.
  - An in-flight memory request is abandoned (mem_req drops immediately); no completion pulse follows.
- Read capture:
  - cpu_en high and rd_pend clear: at the clock edge, set rd_pend and latch rd_addr.
  - cpu_en high and rd_pend set: ignore the request; set err_rd.
- Write buffer:
  - cpu_wr_en pushes {cpu_addr, cpu_wdata}.
  - A pop happens on mem_ack in CPU_W.
  - Push while full with a same-cycle pop: accepted, count unchanged.
  - Push while full without a pop: dropped; set err_ovf.
  - Writes drain in FIFO order.
  - cpu_wbuf_full = (count == WBUF_DEPTH).
- Eligibility (evaluated in IDLE only):
  - cpu_w = buffer non-empty.
  - cpu_r = rd_pend AND buffer empty. Reads never pass older buffered writes.
  - dma = dma_req.
- FSM states: IDLE, CPU_W, CPU_R, DMA_X.
- Transitions out of IDLE:
  - If a CPU request (cpu_w or cpu_r) and dma are both eligible:
    - streak >= CPU_BURST: go to DMA_X, streak := 0.
    - otherwise: CPU, streak := streak+1 (saturating).
  - If only CPU is eligible: CPU, streak := streak+1 (saturating).
  - If only DMA is eligible: DMA_X, streak := 0.
  - CPU choice: CPU_W if cpu_w, else CPU_R.
- Memory outputs are registered:
  - On entering a busy state, mem_req=1 and mem_wr/mem_addr/mem_wdata are loaded from the buffer head, rd_addr, or dma_* respectively.
  - Held stable until mem_ack.
- On mem_ack (busy state → IDLE, mem_req=0 next cycle):
  - CPU_W: pop the buffer head.
  - CPU_R: cpu_rdata := mem_rdata; cpu_valid=1 next cycle; rd_pend cleared.
  - DMA_X: dma_rdata := mem_rdata (reads only); dma_done=1 next cycle.
- mem_ack outside a busy state is ignored.
- Latency, zero-wait memory:
  - cpu_en at cycle t → mem_req at t+2 → mem_ack at t+2 → cpu_valid at t+3.
  - Minimum 2 cycles per transaction (one IDLE cycle between transactions).
- A new cpu_en may arrive in the cycle that cpu_valid is high (rd_pend is already clear).

Test Plan:
- CPU read, zero-wait: cpu_en cycle 0, addr 0x100; mem_ack with 0xDEADBEEF when mem_req → mem_req=1, mem_wr=0, mem_addr=0x100 at cycle 2; cpu_valid=1 at cycle 3; cpu_rdata=0xDEADBEEF.
- Ordering: write 0x40←0x11 cycle 0, read 0x40 cycle 1 → memory sees write (mem_wr=1, 0x11) before read; read issued only after buffer empty; cpu_valid follows the read ack.
- Overflow: mem_ack held low, 5 writes cycles 0-4 → cpu_wbuf_full=1 after 4th; err_ovf=1 after 5th; release acks → exactly 4 writes issued in push order.
- Fairness: dma_req held high, 4 CPU writes buffered, CPU_BURST=2, immediate acks → grant order CPU,CPU,DMA,CPU,CPU,DMA; each dma_done one cycle after its ack.
- Double read: cpu_en cycles 0 and 1, mem_ack withheld → err_rd=1; one memory read issued, one cpu_valid.
- Reset mid-transaction: rst asserted during DMA_X with mem_req=1 → mem_req=0 immediately; no dma_done; after release arb_idle=1 and cpu_wbuf_full=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between CPU (posted writes + pulsed reads) and DMA (level req/done).
// One registered transaction at a time; CPU-biased, with DMA forced in after CPU_BURST CPU grants.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int CPU_BURST  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wbuf_full,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_idle,
    output logic              err_ovf,
    output logic              err_rd
);

    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (CPU_BURST > 0) ? $clog2(CPU_BURST + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CPU_W = 2'd1,
        S_CPU_R = 2'd2,
        S_DMA_X = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_d [WBUF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_valid_q, cpu_valid_d, dma_done_q, dma_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic              err_ovf_q, err_ovf_d, err_rd_q, err_rd_d;

    logic full, push, pop, cpu_w_el, cpu_r_el, cpu_el, dma_el;

    assign full     = (count_q == CW'(WBUF_DEPTH));
    assign pop      = (state_q == S_CPU_W) && mem_ack;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push     = cpu_wr_en && (!full || pop);
    assign cpu_w_el = (count_q != '0);
    assign cpu_r_el = rd_pend_q && (count_q == '0);
    assign cpu_el   = cpu_w_el || cpu_r_el;
    assign dma_el   = dma_req;

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        if (push) begin
            wb_addr_d[wr_ptr_q] = cpu_addr;
            wb_data_d[wr_ptr_q] = cpu_wdata;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (cpu_wr_en && full && !pop) begin
            err_ovf_d = 1'b1;
        end
    end

    always_comb begin
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        err_rd_d  = err_rd_q;
        if ((state_q == S_CPU_R) && mem_ack) begin
            rd_pend_d = 1'b0;
        end
        if (cpu_en) begin
            if (!rd_pend_q) begin
                rd_pend_d = 1'b1;
                rd_addr_d = cpu_addr;
            end else begin
                err_rd_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_valid_d = 1'b0;
        dma_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dma_el && (!cpu_el || (streak_q >= SW'(CPU_BURST)))) begin
                    state_d     = S_DMA_X;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = dma_wr;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                end else if (cpu_el) begin
                    if (streak_q < SW'(CPU_BURST)) begin
                        streak_d = streak_q + SW'(1);
                    end
                    mem_req_d = 1'b1;
                    if (cpu_w_el) begin
                        state_d     = S_CPU_W;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = wb_addr_q[rd_ptr_q];
                        mem_wdata_d = wb_data_q[rd_ptr_q];
                    end else begin
                        state_d     = S_CPU_R;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = rd_addr_q;
                        mem_wdata_d = '0;
                    end
                end
            end
            default: begin
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == S_CPU_R) begin
                        cpu_rdata_d = mem_rdata;
                        cpu_valid_d = 1'b1;
                    end
                    if (state_q == S_DMA_X) begin
                        if (!mem_wr_q) begin
                            dma_rdata_d = mem_rdata;
                        end
                        dma_done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_valid_q <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            err_ovf_q   <= 1'b0;
            err_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_valid_q <= cpu_valid_d;
            dma_done_q  <= dma_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            err_ovf_q   <= err_ovf_d;
            err_rd_q    <= err_rd_d;
        end
    end

    assign cpu_valid     = cpu_valid_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign cpu_wbuf_full = full;
    assign dma_done      = dma_done_q;
    assign dma_rdata     = dma_rdata_q;
    assign mem_req       = mem_req_q;
    assign mem_wr        = mem_wr_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign err_ovf       = err_ovf_q;
    assign err_rd        = err_rd_q;
    assign arb_idle      = (state_q == S_IDLE) && (count_q == '0) && !rd_pend_q && !dma_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for ordering,
// overflow, fairness, double read and reset during a transaction.
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk, rst;
    logic        cpu_en, cpu_wr_en;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_wbuf_full;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_done;
    logic [31:0] dma_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        arb_idle, err_ovf, err_rd;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WBUF_DEPTH(4), .CPU_BURST(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_wbuf_full(cpu_wbuf_full),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .arb_idle(arb_idle), .err_ovf(err_ovf), .err_rd(err_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        log_q[$];
    int          valid_cnt = 0;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        p_rd = 1'b0, p_dma = 1'b0;

    // Memory model and protocol monitor; DMA addresses have bit 31 set, CPU addresses do not.
    always @(negedge clk) begin
        if (rst) begin
            p_rd    = 1'b0;
            p_dma   = 1'b0;
            mem_ack = 1'b0;
        end else begin
            chk("cpu_valid_timing", 64'(cpu_valid), 64'(p_rd));
            chk("dma_done_timing", 64'(dma_done), 64'(p_dma));
            if (cpu_valid) valid_cnt++;
            mem_ack   = auto_ack ? mem_req : man_ack;
            mem_rdata = auto_ack ? (mem_addr ^ K) : man_rdata;
            p_rd  = mem_req && mem_ack && !mem_wr && !mem_addr[31];
            p_dma = mem_req && mem_ack && mem_addr[31];
            if (mem_req && mem_ack) log_q.push_back({mem_wr, mem_addr, mem_wdata});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cpu_en    = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_wr    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        man_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while (!arb_idle && n < lim) begin
            mid();
            n++;
        end
        chk(nm, 64'(arb_idle), 64'd1);
    endtask

    task automatic chk_txn(input string nm, input int idx, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (idx < log_q.size()) begin
            chk({nm, "_wr"}, 64'(log_q[idx].wr), 64'(wr));
            chk({nm, "_addr"}, 64'(log_q[idx].addr), 64'(addr));
            if (wr) chk({nm, "_wdata"}, 64'(log_q[idx].wdata), 64'(wd));
        end else begin
            chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
        end
    endtask

    typedef struct {
        logic        en, wen;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic        e_valid;
        logic [31:0] e_rdata;
        logic        e_idle;
    } vec_t;

    function automatic vec_t mkv(input logic en, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                                 input logic e_req, input logic e_wr, input logic [31:0] e_addr,
                                 input logic [31:0] e_wdata, input logic e_valid,
                                 input logic [31:0] e_rdata, input logic e_idle);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_valid = e_valid; v.e_rdata = e_rdata; v.e_idle = e_idle;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        int base;
        int vbase;
        int dseen;
        int n;

        // zero-wait read of 0x100, then write 0x40<-0x11 followed by read of 0x40
        vecs[0]  = mkv(1, 0, 32'h100, 0,     0, 0,            0, 0, 0,      0,     0, 0,            1);
        vecs[1]  = mkv(0, 0, 0,       0,     0, 0,            0, 0, 0,      0,     0, 0,            0);
        vecs[2]  = mkv(0, 0, 0,       0,     1, 32'hDEADBEEF, 1, 0, 32'h100, 0,    0, 0,            0);
        vecs[3]  = mkv(0, 0, 0,       0,     0, 0,            0, 0, 0,      0,     1, 32'hDEADBEEF, 1);
        vecs[4]  = mkv(0, 0, 0,       0,     0, 0,            0, 0, 0,      0,     0, 32'hDEADBEEF, 1);
        vecs[5]  = mkv(0, 1, 32'h40,  32'h11, 0, 0,           0, 0, 0,      0,     0, 32'hDEADBEEF, 1);
        vecs[6]  = mkv(1, 0, 32'h40,  0,     0, 0,            0, 0, 0,      0,     0, 32'hDEADBEEF, 0);
        vecs[7]  = mkv(0, 0, 0,       0,     1, 0,            1, 1, 32'h40, 32'h11, 0, 32'hDEADBEEF, 0);
        vecs[8]  = mkv(0, 0, 0,       0,     0, 0,            0, 0, 0,      0,     0, 32'hDEADBEEF, 0);
        vecs[9]  = mkv(0, 0, 0,       0,     1, 32'h55,       1, 0, 32'h40, 0,     0, 32'hDEADBEEF, 0);
        vecs[10] = mkv(0, 0, 0,       0,     0, 0,            0, 0, 0,      0,     1, 32'h55,       1);

        do_reset();
        mid();
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_cpu_valid", 64'(cpu_valid), 0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 0);
        chk("rst_dma_done", 64'(dma_done), 0);
        chk("rst_dma_rdata", 64'(dma_rdata), 0);
        chk("rst_full", 64'(cpu_wbuf_full), 0);
        chk("rst_arb_idle", 64'(arb_idle), 1);
        chk("rst_err_ovf", 64'(err_ovf), 0);
        chk("rst_err_rd", 64'(err_rd), 0);

        for (int i = 0; i < 11; i++) begin
            next_cycle();
            cpu_en    = vecs[i].en;
            cpu_wr_en = vecs[i].wen;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            man_ack   = vecs[i].ack;
            man_rdata = vecs[i].rdata;
            mid();
            chk($sformatf("vec%0d_mem_req", i), 64'(mem_req), 64'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_mem_wr", i), 64'(mem_wr), 64'(vecs[i].e_wr));
                chk($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
                if (vecs[i].e_wr)
                    chk($sformatf("vec%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wdata));
            end
            chk($sformatf("vec%0d_cpu_valid", i), 64'(cpu_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].e_rdata));
            chk($sformatf("vec%0d_arb_idle", i), 64'(arb_idle), 64'(vecs[i].e_idle));
            chk($sformatf("vec%0d_errs", i), 64'({err_ovf, err_rd}), 0);
        end
        next_cycle();
        cpu_en = 1'b0; cpu_wr_en = 1'b0; man_ack = 1'b0;

        // overflow: five pushes with memory stalled, fifth is dropped
        do_reset();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            cpu_wr_en = 1'b1;
            cpu_addr  = 32'h200 + 32'(4 * c);
            cpu_wdata = 32'hA0 + 32'(c);
            mid();
            chk($sformatf("ovf_full_c%0d", c), 64'(cpu_wbuf_full), (c >= 4) ? 64'd1 : 64'd0);
            chk($sformatf("ovf_err_c%0d", c), 64'(err_ovf), 0);
        end
        next_cycle();
        cpu_wr_en = 1'b0;
        mid();
        chk("ovf_err_set", 64'(err_ovf), 1);
        chk("ovf_full_hold", 64'(cpu_wbuf_full), 1);
        chk("ovf_head_addr", 64'(mem_addr), 64'h200);
        base = log_q.size();
        auto_ack = 1'b1;
        wait_idle("ovf_drain_timeout", 40);
        chk("ovf_txn_count", 64'(log_q.size() - base), 4);
        for (int i = 0; i < 4; i++)
            chk_txn($sformatf("ovf_txn%0d", i), base + i, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("ovf_err_sticky", 64'(err_ovf), 1);
        chk("ovf_full_clear", 64'(cpu_wbuf_full), 0);

        // fairness: DMA waiting while four CPU writes are buffered
        do_reset();
        auto_ack  = 1'b1;
        dma_wr    = 1'b1;
        dma_addr  = 32'h8000_0000;
        dma_wdata = 32'hD0;
        base = log_q.size();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            cpu_wr_en = 1'b1;
            cpu_addr  = 32'h300 + 32'(4 * c);
            cpu_wdata = 32'hC0 + 32'(c);
            dma_req   = (c >= 1);
        end
        next_cycle();
        cpu_wr_en = 1'b0;
        dseen = 0;
        n = 0;
        while (!(dseen == 2 && arb_idle) && n < 80) begin
            mid();
            n++;
            if (dma_done) begin
                dseen++;
                if (dseen == 1) begin
                    dma_wr   = 1'b0;
                    dma_addr = 32'h8000_0004;
                end else begin
                    dma_req = 1'b0;
                end
            end
        end
        chk("fair_timeout", 64'(dseen == 2 && arb_idle), 1);
        chk("fair_txn_count", 64'(log_q.size() - base), 6);
        chk_txn("fair0_cpu", base + 0, 1'b1, 32'h300, 32'hC0);
        chk_txn("fair1_cpu", base + 1, 1'b1, 32'h304, 32'hC1);
        chk_txn("fair2_dma", base + 2, 1'b1, 32'h8000_0000, 32'hD0);
        chk_txn("fair3_cpu", base + 3, 1'b1, 32'h308, 32'hC2);
        chk_txn("fair4_cpu", base + 4, 1'b1, 32'h30C, 32'hC3);
        chk_txn("fair5_dma", base + 5, 1'b0, 32'h8000_0004, 32'h0);
        chk("fair_dma_rdata", 64'(dma_rdata), 64'(32'h8000_0004 ^ K));

        // double read: second cpu_en while first is pending
        do_reset();
        base  = log_q.size();
        vbase = valid_cnt;
        next_cycle();
        cpu_en = 1'b1; cpu_addr = 32'h500;
        next_cycle();
        cpu_en = 1'b1; cpu_addr = 32'h600;
        next_cycle();
        cpu_en = 1'b0;
        mid();
        chk("dbl_err_rd", 64'(err_rd), 1);
        chk("dbl_mem_req", 64'(mem_req), 1);
        chk("dbl_mem_addr", 64'(mem_addr), 64'h500);
        repeat (3) next_cycle();
        auto_ack = 1'b1;
        wait_idle("dbl_timeout", 20);
        repeat (2) mid();
        chk("dbl_txn_count", 64'(log_q.size() - base), 1);
        chk_txn("dbl_txn", base, 1'b0, 32'h500, 32'h0);
        chk("dbl_valid_count", 64'(valid_cnt - vbase), 1);
        chk("dbl_rdata", 64'(cpu_rdata), 64'(32'h500 ^ K));

        // reset while a DMA transaction is outstanding
        do_reset();
        next_cycle();
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h8000_0010; dma_wdata = 32'hEE;
        next_cycle();
        mid();
        chk("rmid_req_before", 64'(mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rmid_req_drop", 64'(mem_req), 0);
        dma_req = 1'b0;
        #1;
        chk("rmid_idle_in_rst", 64'(arb_idle), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("rmid_no_done%0d", c), 64'(dma_done), 0);
            chk($sformatf("rmid_idle%0d", c), 64'(arb_idle), 1);
            chk($sformatf("rmid_full%0d", c), 64'(cpu_wbuf_full), 0);
            chk($sformatf("rmid_req%0d", c), 64'(mem_req), 0);
        end
        chk("rmid_dma_rdata", 64'(dma_rdata), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
